// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time,
// buffers the returned word for decode. Optional misaligned-redirect fault: FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic        fetch_valid,
  output logic        fetch_misaligned
);

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MISALIGN_CHK = 1'b1;
`else
  localparam bit MISALIGN_CHK = 1'b0;
`endif

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, buf_instr, buf_pc;
  logic        fault_pend;
  logic [31:0] redir_pc_eff;
  logic        redir_mis;

  // Without the check the low bits are simply dropped, so the PC stays word-aligned.
  assign redir_mis    = MISALIGN_CHK && (redirect_pc[1:0] != 2'b00);
  assign redir_pc_eff = MISALIGN_CHK ? redirect_pc : {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      // An in-flight response must be swallowed before anything else happens.
      if ((state == S_WAIT || state == S_DRAIN) && !imem_rsp_valid) state_nxt = S_DRAIN;
      else state_nxt = redir_mis ? S_FAULT : S_REQ;
    end else begin
      case (state)
        S_REQ:   if (imem_req_ready) state_nxt = S_WAIT;
        S_WAIT:  if (imem_rsp_valid) state_nxt = S_HOLD;
        S_HOLD:  if (!stall_in) state_nxt = imem_req_ready ? S_WAIT : S_REQ;
        S_DRAIN: if (imem_rsp_valid) state_nxt = fault_pend ? S_FAULT : S_REQ;
        S_FAULT: state_nxt = S_FAULT;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req_valid   = !redirect_valid &&
                       ((state == S_REQ) || (state == S_HOLD && !stall_in));
    imem_req_addr    = pc;
    fetch_valid      = (state == S_HOLD);
    instr_f          = (state == S_HOLD) ? buf_instr : NOP_INSTR;
    pc_f             = buf_pc;
    fetch_misaligned = MISALIGN_CHK && (state == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      buf_instr  <= NOP_INSTR;
      buf_pc     <= 32'h0;
      fault_pend <= 1'b0;
    end else if (redirect_valid) begin
      pc         <= redir_pc_eff;
      fault_pend <= redir_mis && (state_nxt == S_DRAIN);
    end else begin
      if (state == S_WAIT && imem_rsp_valid) begin
        buf_instr <= imem_rsp_data;
        buf_pc    <= pc;
        pc        <= pc + 32'd4;
      end
      if (state == S_DRAIN && imem_rsp_valid) fault_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level reference model plus a latency-programmable
// imem model; directed scenarios with literal checks, then a randomized run.
module tb_fetch_unit;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] SENT = 32'h0000_0001;

  logic clk = 1'b0;
  logic reset = 1'b1, stall_in = 1'b0, redirect_valid = 1'b0, imem_req_ready = 1'b1;
  logic [31:0] redirect_pc = '0;
  logic imem_req_valid, imem_rsp_valid = 1'b0, fetch_valid, fetch_misaligned;
  logic [31:0] imem_req_addr, imem_rsp_data = '0, instr_f, pc_f;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall_in(stall_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_f(instr_f), .pc_f(pc_f),
    .fetch_valid(fetch_valid), .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  // Reference model: what the fetch stage owes, in transaction terms.
  logic [31:0] m_pc = '0, m_buf = NOP, m_bpc = '0;
  bit m_out = 0, m_disc = 0, m_have = 0, m_fault = 0, m_fpend = 0;

  // Memory model: one slot, response at a chosen cycle.
  bit mem_busy = 0;
  logic [31:0] mem_addr = '0;
  int mem_at = 0, lat_fixed = 1;
  logic [31:0] slow_addr = SENT, bad_addr = SENT;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit exp_req();
    return !redirect_valid && !m_out && !m_fault && !(m_have && stall_in);
  endfunction

  function automatic int lat_of(input logic [31:0] a);
    if (a == slow_addr) return 3;
    if (lat_fixed > 0) return lat_fixed;
    return int'($urandom_range(1, 4));
  endfunction

  // Advance model and memory by one clock using the inputs of the cycle just ended.
  task automatic step();
    bit acc, mis;
    acc = !reset && exp_req() && imem_req_ready;
    if (reset) mem_busy = 0;
    else begin
      if (imem_rsp_valid) mem_busy = 0;
      if (acc) begin mem_busy = 1; mem_addr = m_pc; mem_at = cyc + lat_of(m_pc); end
    end
    if (reset) begin
      m_pc = 32'h0; m_out = 0; m_disc = 0; m_have = 0; m_buf = NOP; m_bpc = 32'h0;
      m_fault = 0; m_fpend = 0;
    end else if (redirect_valid) begin
      mis = CHK && (redirect_pc[1:0] != 2'b00);
      m_pc = CHK ? redirect_pc : {redirect_pc[31:2], 2'b00};
      m_have = 0;
      if (m_out && !imem_rsp_valid) m_disc = 1;
      else begin m_out = 0; m_disc = 0; end
      m_fpend = mis && m_out;
      m_fault = mis && !m_out;
    end else begin
      if (m_out && imem_rsp_valid) begin
        m_out = 0;
        if (!m_disc) begin m_have = 1; m_buf = imem_rsp_data; m_bpc = m_pc; m_pc = m_pc + 32'd4; end
        m_disc = 0;
        if (m_fpend) m_fault = 1;
        m_fpend = 0;
      end else if (m_have && !stall_in) m_have = 0;
      if (acc) m_out = 1;
    end
    cyc++;
  endtask

  task automatic cycle(input bit r, input bit st, input bit rv, input logic [31:0] rp, input bit rdy);
    @(posedge clk);
    step();
    #1;
    reset = r; stall_in = st; redirect_valid = rv; redirect_pc = rp; imem_req_ready = rdy;
    imem_rsp_valid = mem_busy && !r && (cyc == mem_at);
    imem_rsp_data = imem_rsp_valid ? ((mem_addr == bad_addr) ? 32'hDEAD_BEEF : (mem_addr ^ 32'hA5A5_0000))
                                   : $urandom;
    @(negedge clk);
  endtask

  task automatic go(); cycle(0, 0, 0, 32'h0, 1); endtask
  task automatic rst(); cycle(1, 0, 0, 32'h0, 1); chk_en = 1'b1; endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_have});
      chk("instr_f", instr_f, m_have ? m_buf : NOP);
      chk("pc_f", pc_f, m_bpc);
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req()});
      chk("req_addr", imem_req_addr, m_pc);
      chk("misaligned", {31'b0, fetch_misaligned}, {31'b0, m_fault});
    end
  end

  initial begin
    // Throughput with L=1 and reset state.
    lat_fixed = 1;
    rst();
    go();
    chk("rst_fv", {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr", instr_f, 32'h0000_0013);
    chk("rst_pc_f", pc_f, 32'h0);
    chk("rst_req", {31'b0, imem_req_valid}, 32'd1);
    chk("rst_addr", imem_req_addr, 32'h0);
    chk("rst_mis", {31'b0, fetch_misaligned}, 32'd0);
    go(); chk("c1_req", {31'b0, imem_req_valid}, 32'd0);
    go(); chk("c2_fv", {31'b0, fetch_valid}, 32'd1); chk("c2_pc", pc_f, 32'h0);
    chk("c2_instr", instr_f, 32'hA5A5_0000); chk("c2_addr", imem_req_addr, 32'h4);
    go(); chk("c3_fv", {31'b0, fetch_valid}, 32'd0);
    go(); chk("c4_pc", pc_f, 32'h4); chk("c4_instr", instr_f, 32'hA5A5_0004);
    go(); go(); chk("c6_pc", pc_f, 32'h8); chk("c6_instr", instr_f, 32'hA5A5_0008);

    // Stall for 3 cycles while HOLD shows 0x4.
    rst(); repeat (4) go();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 32'h0, 1);
      chk("stall_fv", {31'b0, fetch_valid}, 32'd1);
      chk("stall_pc", pc_f, 32'h4);
      chk("stall_instr", instr_f, 32'hA5A5_0004);
      chk("stall_req", {31'b0, imem_req_valid}, 32'd0);
    end
    go(); chk("unstall_req", {31'b0, imem_req_valid}, 32'd1); chk("unstall_addr", imem_req_addr, 32'h8);

    // Redirect while waiting for 0x8; the stale response carries DEADBEEF.
    slow_addr = 32'h8; bad_addr = 32'h8;
    rst(); repeat (5) go();
    cycle(0, 0, 1, 32'h100, 1); chk("redir_req", {31'b0, imem_req_valid}, 32'd0);
    go(); chk("drain_fv", {31'b0, fetch_valid}, 32'd0); chk("drain_req", {31'b0, imem_req_valid}, 32'd0);
    go(); chk("drain_rsp_req", {31'b0, imem_req_valid}, 32'd0);
    go(); chk("after_drain_req", {31'b0, imem_req_valid}, 32'd1); chk("after_drain_addr", imem_req_addr, 32'h100);
    go(); go(); chk("redir_fv", {31'b0, fetch_valid}, 32'd1); chk("redir_pc", pc_f, 32'h100);
    chk("redir_instr", instr_f, 32'hA5A5_0100);
    slow_addr = SENT; bad_addr = SENT;

    // Memory not ready for 4 cycles.
    rst();
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 32'h0, 0);
      chk("nrdy_req", {31'b0, imem_req_valid}, 32'd1);
      chk("nrdy_addr", imem_req_addr, 32'h0);
    end
    go();

    // Redirect and stall together in HOLD.
    rst(); go(); go();
    cycle(0, 1, 1, 32'h40, 1); chk("rs_req", {31'b0, imem_req_valid}, 32'd0);
    go(); chk("rs_fv", {31'b0, fetch_valid}, 32'd0); chk("rs_req2", {31'b0, imem_req_valid}, 32'd1);
    chk("rs_addr", imem_req_addr, 32'h40);

    // Misaligned redirect.
    rst();
    cycle(0, 0, 1, 32'h102, 1);
    go();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_flag", {31'b0, fetch_misaligned}, 32'd1); chk("mis_req", {31'b0, imem_req_valid}, 32'd0);
`else
    chk("mis_flag", {31'b0, fetch_misaligned}, 32'd0); chk("mis_addr", imem_req_addr, 32'h100);
`endif
    cycle(0, 0, 1, 32'h200, 1);
    go(); chk("mis_clr", {31'b0, fetch_misaligned}, 32'd0);
    chk("mis_clr_req", {31'b0, imem_req_valid}, 32'd1); chk("mis_clr_addr", imem_req_addr, 32'h200);

    // Randomized run against the model.
    lat_fixed = 0;
    rst();
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
      if ($urandom_range(0, 3) == 0) rp[1:0] = 2'($urandom_range(1, 3));
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 11) == 0, rp, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the five-stage RISC-V pipeline. It owns the program counter, issues word requests to instruction memory over a valid/ready request and valid-only response channel, and presents `instr_f`/`pc_f` to the fetch/decode pipeline register. It honours decode back-pressure (`stall_in`) and control-flow redirects from execute (`redirect_valid`/`redirect_pc`). At most one memory request is outstanding at any time.

## Interface
- `RESET_PC`, 32'h0000_0000, PC after reset; must be word-aligned.
- `NOP_INSTR`, 32'h0000_0013, value driven on `instr_f` when no valid instruction is presented (`addi x0,x0,0`).

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `stall_in`  in  1  decode cannot accept; fetch outputs must hold stable.
- `redirect_valid`  in  1  taken branch/jump/flush from execute.
- `redirect_pc`  in  32  new fetch PC, sampled when `redirect_valid`=1.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  request word address.
- `imem_rsp_valid`  in  1  response data valid, one pulse per accepted request, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `instr_f`  out  32  instruction to the fetch/decode register.
- `pc_f`  out  32  PC of `instr_f`.
- `fetch_valid`  out  1  `instr_f`/`pc_f` carry a real instruction.
- `fetch_misaligned`  out  1  misaligned redirect fault (see Configuration).

## Operation
- Registers: `pc`, `buf_instr`, `buf_pc`, `state`.
- A transfer to decode occurs in any cycle with `fetch_valid`=1 and `stall_in`=0.
- `instr_f` = `buf_instr` in HOLD, else `NOP_INSTR`; `pc_f` = `buf_pc`; `fetch_valid` = (state==HOLD).
- States:
  - REQ: `imem_req_valid`=1, addr=`pc`. On `imem_req_ready` → WAIT.
  - WAIT: no request. On `imem_rsp_valid`: `buf_instr`←data, `buf_pc`←`pc`, `pc`←`pc`+4 (mod 2^32, wraps silently) → HOLD.
  - HOLD: present buffer. If `stall_in`=1, `imem_req_valid`=0, stay. Else `imem_req_valid`=1, addr=`pc`; on ready → WAIT, otherwise → REQ.
  - DRAIN: a request issued before a redirect is still outstanding; on `imem_rsp_valid` discard data → REQ.
- Redirect has priority over stall and over every state:
  - `pc`←`redirect_pc` and `imem_req_valid` is forced to 0 that cycle.
  - From REQ or HOLD → REQ.
  - From WAIT or DRAIN → REQ if `imem_rsp_valid` is high in the same cycle (data discarded), else → DRAIN.
- `imem_rsp_valid` in REQ or HOLD is a protocol violation and is ignored.
- `imem_req_addr` is `pc` in all states; it is stable while `imem_req_valid`=1 and not accepted.

## Timing
- Reset (any cycle, including mid-request): `pc`←`RESET_PC`, state←REQ, `buf_instr`←`NOP_INSTR`, `buf_pc`←0. After reset: `fetch_valid`=0, `instr_f`=`NOP_INSTR`, `pc_f`=0, `imem_req_valid`=1 from the first post-reset cycle, `fetch_misaligned`=0. Instruction memory shares `reset` and discards its in-flight response.
- Latency: request accepted cycle N, response N+L → `fetch_valid`=1 at N+L+1.
- Throughput with L=1 and no stalls: one instruction per 2 cycles.
- Redirect in cycle R: `fetch_valid`=0 at R+1; first request to `redirect_pc` at R+1 (from REQ) or the cycle after the drained response.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 enters FAULT: no requests, `fetch_valid`=0, `fetch_misaligned`=1.
  - Any pending response is still drained first; `fetch_misaligned` asserts when FAULT is entered.
  - FAULT exits only on reset or an aligned redirect (→ REQ).
- Not defined: `redirect_pc[1:0]` is ignored (treated as 00), and `fetch_misaligned` is tied to 0.

## Test plan
- Reset, ready=1, L=1 memory returning data=addr^32'hA5A5_0000: requests to 0x0, 0x4, 0x8; `fetch_valid` pulses every other cycle with `pc_f`=0x0/0x4/0x8 and matching `instr_f`.
- `stall_in`=1 for 3 cycles while HOLD shows pc 0x4: `instr_f`/`pc_f` are held, `imem_req_valid`=0; on release, a request to 0x8 issues in the same cycle.
- Redirect to 0x100 in WAIT for 0x8; the response 32'hDEAD_BEEF arrives 2 cycles later: it never appears on `instr_f`, and the next request is to 0x100.
- `imem_req_ready`=0 for 4 cycles in REQ: `imem_req_addr` stays at 0x0 and `imem_req_valid` stays at 1 throughout.
- Redirect to 0x40 and `stall_in`=1 in the same cycle during HOLD: the redirect wins, `fetch_valid`=0 next cycle, and the next request is to 0x40.
- With the macro defined, redirect to 0x102: `fetch_misaligned`=1 and no requests are issued. A following redirect to 0x200 clears the fault and issues a request to 0x200.
